// File: rtl/cla_nibble_serial_adder_pkg.sv
// rtl/cla_nibble_serial_adder_pkg.sv - shared types and constants for the nibble-serial CLA adder
package cla_nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // A single-nibble index still needs one bit of storage.
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/cla_nibble_serial_adder_cla4_slice.sv
// rtl/cla_nibble_serial_adder_cla4_slice.sv - combinational 4-bit carry-lookahead slice
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c3,
  output logic       c4
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;

  assign p  = a ^ b;
  assign g  = a & b;
  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  // c4 fully expanded so it does not serialise behind c3.
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c0);
  assign s  = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// rtl/cla_nibble_serial_adder.sv - multi-word add/sub streaming one nibble per clock through a CLA slice
module cla_nibble_serial_adder
  import cla_nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [3:0]       slice_s;
  logic             slice_c3;
  logic             slice_c4;

  cla4_slice slice (
    .a  (op_a[int'(idx)*NIBBLE_W +: NIBBLE_W]),
    .b  (op_b[int'(idx)*NIBBLE_W +: NIBBLE_W]),
    .c0 (carry),
    .s  (slice_s),
    .c3 (slice_c3),
    .c4 (slice_c4)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1, so the +1 rides in on the initial carry.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[int'(idx)*NIBBLE_W +: NIBBLE_W] <= slice_s;
          carry <= slice_c4;
          if (idx == LAST_IDX) begin
            cout <= slice_c4;
            ovf  <= slice_c3 ^ slice_c4;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
